// File: rtl/i2c_rx_byte_packer.sv
// i2c_rx_byte_packer: packs RX FIFO bytes little-endian into OutWidth-bit words
module i2c_rx_byte_packer #(
  parameter  int OutWidth = 32,
  parameter  int TimeoutW = 8,
  localparam int NumBytes = OutWidth / 8,
  localparam int CntW     = $clog2(NumBytes + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [7:0]          in_data_i,
  input  logic                flush_i,
  input  logic [TimeoutW-1:0] timeout_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [OutWidth-1:0] out_data_o,
  output logic [CntW-1:0]     out_bytes_o,
  output logic                busy_o
);
  typedef enum logic {FILL, HOLD} state_e;
  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, obytes_q, obytes_d, cnt_inc;
  logic [OutWidth-1:0] acc_q, acc_d;
  logic [TimeoutW-1:0] idle_q, idle_d;
  logic                accept, expiry, flush_ev;
  assign in_ready_o  = rst_ni & ((state_q == FILL) | out_ready_i);
  assign out_valid_o = rst_ni & (state_q == HOLD);
  assign out_data_o  = (state_q == HOLD) ? acc_q : '0;
  assign out_bytes_o = (state_q == HOLD) ? obytes_q : '0;
  assign busy_o      = (state_q == HOLD) | (cnt_q != '0);
  assign accept      = in_valid_i & in_ready_o;
  assign cnt_inc     = cnt_q + CntW'(accept);
  assign expiry      = (state_q == FILL) & ~accept & (cnt_q != '0) & (timeout_i != '0) &
                       (({1'b0, idle_q} + 1'b1) == {1'b0, timeout_i});
  assign flush_ev    = flush_i | expiry;
  // Next-state logic: byte placement, idle timer, and word hand-off
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    idle_d   = idle_q;
    obytes_d = obytes_q;
    if (state_q == FILL) begin
      if (accept) begin
        for (int k = 0; k < NumBytes; k++)
          if (CntW'(k) == cnt_q) acc_d[8*k +: 8] = in_data_i;
        cnt_d  = cnt_inc;
        idle_d = '0;
      end else begin
        idle_d = (cnt_q == '0 || timeout_i == '0) ? '0 : (&idle_q ? idle_q : idle_q + 1'b1);
      end
      if (cnt_inc == CntW'(NumBytes) || (flush_ev && cnt_inc != '0)) begin
        state_d  = HOLD;
        obytes_d = cnt_inc;
        idle_d   = '0;
      end
    end else begin
      idle_d = '0;
      if (out_ready_i) begin
        state_d = FILL;
        cnt_d   = CntW'(accept);
        acc_d   = {{(OutWidth-8){1'b0}}, accept ? in_data_i : 8'h00};
      end
    end
  end
  // State register; reset and clear both return to an empty FILL
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      acc_q    <= '0;
      idle_q   <= '0;
      obytes_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idle_q   <= idle_d;
      obytes_q <= obytes_d;
    end
  end
endmodule
